// File: rtl/nave_ctrl.sv
// Player ship controller: position, fire pulses, lives and hit/invulnerability state.
// Ports: CLOCK_50/reset (sync, active-low); keysout/tiro/pausa/reiniciarJogo/bateu in;
//        x_nave/y_nave/largura_nave/altura_nave, tiro_pulso, vidas, invulneravel, fim_jogo out.
module nave_ctrl #(
  parameter int SCREEN_W      = 640,
  parameter int SCREEN_H      = 480,
  parameter int SHIP_W        = 15,
  parameter int SHIP_H        = 17,
  parameter int X0            = 350,
  parameter int Y0            = 420,
  parameter int Y_MIN         = 240,
  parameter int STEP          = 2,
  parameter int MOVE_DIV      = 250000,
  parameter int FIRE_COOLDOWN = 5000000,
  parameter int LIVES         = 3,
  parameter int INVULN_CYCLES = 50000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [3:0] keysout,
  input  logic       tiro,
  input  logic       pausa,
  input  logic       reiniciarJogo,
  input  logic       bateu,
  output logic [9:0] x_nave,
  output logic [9:0] y_nave,
  output logic [9:0] largura_nave,
  output logic [9:0] altura_nave,
  output logic       tiro_pulso,
  output logic [2:0] vidas,
  output logic       invulneravel,
  output logic       fim_jogo
);

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int CW = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam int IW = $clog2(INVULN_CYCLES + 1);

  localparam logic [MW-1:0] M_LAST  = MW'(MOVE_DIV - 1);
  localparam logic [CW-1:0] CD_LOAD = CW'(FIRE_COOLDOWN);
  localparam logic [IW-1:0] IV_LOAD = IW'(INVULN_CYCLES);

  localparam logic [10:0] STP11  = 11'(STEP);
  localparam logic [9:0]  STP10  = 10'(STEP);
  localparam logic [10:0] XMAX11 = 11'(SCREEN_W - SHIP_W);
  localparam logic [9:0]  XMAX10 = 10'(SCREEN_W - SHIP_W);
  localparam logic [10:0] YMAX11 = 11'(SCREEN_H - SHIP_H);
  localparam logic [9:0]  YMAX10 = 10'(SCREEN_H - SHIP_H);
  localparam logic [10:0] YTOP11 = 11'(Y_MIN + STEP);
  localparam logic [9:0]  YMIN10 = 10'(Y_MIN);

  typedef enum logic [1:0] {
    VIVO   = 2'd0,
    INVULN = 2'd1,
    FIM    = 2'd2
  } state_t;

  state_t        st_q;
  logic [9:0]    x_q, y_q;
  logic [9:0]    x_d, y_d;
  logic [MW-1:0] mcnt_q;
  logic [CW-1:0] cd_q;
  logic [IW-1:0] iv_q;
  logic [2:0]    vidas_q;
  logic          tiro_prev_q;
  logic          pulso_q;
  logic          invul_q;
  logic          fim_q;

  logic [10:0]   xr, yr;
  logic          go_r, go_l, go_u, go_d;
  logic          tick;
  logic          fire_ok;
  logic          hit_ok;

  // Opposing keys cancel out on each axis.
  assign go_r = keysout[0] & ~keysout[1];
  assign go_l = keysout[1] & ~keysout[0];
  assign go_u = keysout[2] & ~keysout[3];
  assign go_d = keysout[3] & ~keysout[2];

  assign tick = (mcnt_q == M_LAST);

  assign fire_ok = tiro & ~tiro_prev_q
                 & (cd_q == '0)
                 & (st_q != FIM);

  assign hit_ok = bateu & (st_q == VIVO);

  // 11-bit sums so the clamp sees any overflow past the edge.
  always_comb begin
    xr  = {1'b0, x_q} + STP11;
    yr  = {1'b0, y_q} + STP11;
    x_d = x_q;
    y_d = y_q;
    if (go_r) begin
      x_d = (xr > XMAX11) ? XMAX10 : xr[9:0];
    end else if (go_l) begin
      x_d = ({1'b0, x_q} < STP11) ? 10'd0 : x_q - STP10;
    end
    if (go_d) begin
      y_d = (yr > YMAX11) ? YMAX10 : yr[9:0];
    end else if (go_u) begin
      y_d = ({1'b0, y_q} < YTOP11) ? YMIN10 : y_q - STP10;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!reset || reiniciarJogo) begin
      st_q        <= VIVO;
      x_q         <= 10'(X0);
      y_q         <= 10'(Y0);
      mcnt_q      <= '0;
      cd_q        <= '0;
      iv_q        <= '0;
      vidas_q     <= 3'(LIVES);
      tiro_prev_q <= 1'b0;
      pulso_q     <= 1'b0;
      invul_q     <= 1'b0;
      fim_q       <= 1'b0;
    end else begin
      // Tracks the button even while paused, so a press
      // made during a pause never fires afterwards.
      tiro_prev_q <= tiro;
      if (!pausa) begin
        pulso_q <= fire_ok;
        if (fire_ok) begin
          cd_q <= CD_LOAD;
        end else if (cd_q != '0) begin
          cd_q <= cd_q - CW'(1);
        end
        if (st_q != FIM) begin
          mcnt_q <= tick ? '0 : mcnt_q + MW'(1);
          if (tick) begin
            x_q <= x_d;
            y_q <= y_d;
          end
        end
        unique case (st_q)
          VIVO: begin
            if (hit_ok) begin
              vidas_q <= vidas_q - 3'd1;
              if (vidas_q > 3'd1) begin
                st_q    <= INVULN;
                iv_q    <= IV_LOAD;
                invul_q <= 1'b1;
              end else begin
                st_q  <= FIM;
                fim_q <= 1'b1;
              end
            end
          end
          INVULN: begin
            iv_q <= iv_q - IW'(1);
            if (iv_q == IW'(1)) begin
              st_q    <= VIVO;
              invul_q <= 1'b0;
            end
          end
          FIM: begin
            st_q <= FIM;
          end
          default: begin
            st_q <= VIVO;
          end
        endcase
      end
    end
  end

  assign x_nave       = x_q;
  assign y_nave       = y_q;
  assign largura_nave = 10'(SHIP_W);
  assign altura_nave  = 10'(SHIP_H);
  assign tiro_pulso   = pulso_q;
  assign vidas        = vidas_q;
  assign invulneravel = invul_q;
  assign fim_jogo     = fim_q;

endmodule

// File: tb/tb_nave_ctrl.sv
// Testbench for nave_ctrl: movement table plus fire, hit, pause and restart sequences.
// Three instances with different parameters share one set of inputs.
module tb_nave_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keys;
  logic       tiro;
  logic       pausa;
  logic       rein;
  logic       bateu;

  logic [9:0] xd, yd, wd, hd;
  logic       pd, id, fd;
  logic [2:0] vd;

  logic [9:0] xa, ya, wa, ha;
  logic       pa, ia, fa;
  logic [2:0] va;

  logic [9:0] xb, yb, wb, hb;
  logic       pb, ib, fb;
  logic [2:0] vb;

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  nave_ctrl dut_d (
    .CLOCK_50(clk), .reset(rst_n), .keysout(keys), .tiro(tiro),
    .pausa(pausa), .reiniciarJogo(rein), .bateu(bateu),
    .x_nave(xd), .y_nave(yd), .largura_nave(wd), .altura_nave(hd),
    .tiro_pulso(pd), .vidas(vd), .invulneravel(id), .fim_jogo(fd)
  );

  nave_ctrl #(
    .X0(620), .MOVE_DIV(1), .FIRE_COOLDOWN(8), .INVULN_CYCLES(5)
  ) dut_a (
    .CLOCK_50(clk), .reset(rst_n), .keysout(keys), .tiro(tiro),
    .pausa(pausa), .reiniciarJogo(rein), .bateu(bateu),
    .x_nave(xa), .y_nave(ya), .largura_nave(wa), .altura_nave(ha),
    .tiro_pulso(pa), .vidas(va), .invulneravel(ia), .fim_jogo(fa)
  );

  nave_ctrl #(
    .X0(1), .MOVE_DIV(1)
  ) dut_b (
    .CLOCK_50(clk), .reset(rst_n), .keysout(keys), .tiro(tiro),
    .pausa(pausa), .reiniciarJogo(rein), .bateu(bateu),
    .x_nave(xb), .y_nave(yb), .largura_nave(wb), .altura_nave(hb),
    .tiro_pulso(pb), .vidas(vb), .invulneravel(ib), .fim_jogo(fb)
  );

  typedef struct {
    logic       rst_n;
    logic [3:0] keys;
    logic       pau;
    logic       rein;
    int         xa;
    int         ya;
    int         xb;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(string nm, int act, int exp);
    ntot++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic add(logic r, logic [3:0] k, logic p, logic rn,
                     int exa, int eya, int exb);
    vec_t v;
    v.rst_n = r; v.keys = k; v.pau = p; v.rein = rn;
    v.xa = exa; v.ya = eya; v.xb = exb;
    tbl.push_back(v);
  endtask

  initial begin
    int cnt;
    int last;
    int mingap;

    rst_n = 1'b0; keys = '0; tiro = 1'b0;
    pausa = 1'b0; rein = 1'b0; bateu = 1'b0;

    // Reset values of the default-parameter instance
    do_reset();
    chk("rst_x", int'(xd), 350);
    chk("rst_y", int'(yd), 420);
    chk("rst_vidas", int'(vd), 3);
    chk("rst_fim", int'(fd), 0);
    chk("rst_pulso", int'(pd), 0);
    chk("rst_invul", int'(id), 0);
    chk("largura", int'(wd), 15);
    chk("altura", int'(hd), 17);

    // Movement table: rst_n, keys, pausa, rein -> xa, ya, xb
    add(0, 4'b0000, 0, 0, 620, 420, 1);
    add(1, 4'b0010, 0, 0, 618, 420, 0);
    add(1, 4'b0010, 0, 0, 616, 420, 0);
    add(1, 4'b0011, 0, 0, 616, 420, 0);
    add(1, 4'b0001, 0, 0, 618, 420, 2);
    add(1, 4'b0001, 0, 0, 620, 420, 4);
    add(1, 4'b0001, 0, 0, 622, 420, 6);
    add(1, 4'b0001, 0, 0, 624, 420, 8);
    add(1, 4'b0001, 0, 0, 625, 420, 10);
    add(1, 4'b0001, 0, 0, 625, 420, 12);
    add(1, 4'b0000, 0, 0, 625, 420, 12);
    add(1, 4'b0100, 0, 0, 625, 418, 12);
    add(1, 4'b1100, 0, 0, 625, 418, 12);
    add(1, 4'b1000, 0, 0, 625, 420, 12);
    add(1, 4'b1000, 0, 0, 625, 422, 12);
    add(1, 4'b1001, 1, 0, 625, 422, 12);
    add(1, 4'b0110, 1, 0, 625, 422, 12);
    add(1, 4'b0000, 0, 1, 620, 420, 1);
    add(1, 4'b0001, 0, 0, 622, 420, 3);
    add(1, 4'b0001, 0, 0, 624, 420, 5);
    add(1, 4'b0001, 0, 0, 625, 420, 7);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n;
      keys  = tbl[i].keys;
      pausa = tbl[i].pau;
      rein  = tbl[i].rein;
      step();
      chk($sformatf("tbl%0d_xa", i), int'(xa), tbl[i].xa);
      chk($sformatf("tbl%0d_ya", i), int'(ya), tbl[i].ya);
      chk($sformatf("tbl%0d_xb", i), int'(xb), tbl[i].xb);
    end
    rst_n = 1'b1; keys = '0; pausa = 1'b0; rein = 1'b0;

    // Vertical floor and ceiling
    keys = 4'b0100;
    for (int i = 0; i < 100; i++) step();
    chk("y_floor", int'(ya), 240);
    keys = 4'b1000;
    for (int i = 0; i < 150; i++) step();
    chk("y_ceil", int'(ya), 463);
    keys = '0;

    // Fire held for 20 cycles: one pulse, right after the edge
    do_reset();
    tiro = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) chk("fire_first", int'(pa), 1);
      if (pa) cnt++;
    end
    chk("fire_held_cnt", cnt, 1);
    tiro = 1'b0;

    // Fire toggled every 2 cycles: pulses at 0,12,24,36,48
    do_reset();
    cnt = 0; last = -100; mingap = 1000;
    for (int i = 0; i < 60; i++) begin
      tiro = ((i / 2) % 2 == 0);
      step();
      if (pa) begin
        if (i - last < mingap) mingap = i - last;
        last = i;
        cnt++;
      end
    end
    chk("fire_tog_cnt", cnt, 5);
    chk("fire_tog_gap", (mingap >= 8) ? 1 : 0, 1);
    tiro = 1'b0;

    // Cooldown holds while paused; pause edges are dropped
    do_reset();
    tiro = 1'b1; step();
    chk("pc_fire", int'(pa), 1);
    tiro = 1'b0; step();
    chk("pc_one_cycle", int'(pa), 0);
    pausa = 1'b1; cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tiro = (i % 2 == 0) && (i < 9);
      step();
      if (pa) cnt++;
    end
    chk("pc_paused_cnt", cnt, 0);
    pausa = 1'b0; tiro = 1'b0; cnt = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (pa) cnt++;
    end
    tiro = 1'b1; step();
    if (pa) cnt++;
    chk("pc_cd_held", cnt, 0);
    step();
    chk("pc_no_retrig", int'(pa), 0);
    tiro = 1'b0; step();
    tiro = 1'b1; step();
    chk("pc_fire2", int'(pa), 1);
    tiro = 1'b0;
    for (int i = 0; i < 10; i++) step();
    pausa = 1'b1; tiro = 1'b1; step();
    pausa = 1'b0; step();
    chk("pc_pause_edge", int'(pa), 0);
    step();
    chk("pc_pause_edge2", int'(pa), 0);
    tiro = 1'b0;

    // Reset mid-cooldown clears the cooldown
    do_reset();
    tiro = 1'b1; step();
    tiro = 1'b0; step();
    do_reset();
    tiro = 1'b1; step();
    chk("rst_mid_cd", int'(pa), 1);
    tiro = 1'b0; step();

    // Hit sequence: bateu at cycles 0, 2, 10, 20
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      bateu = (c == 0) || (c == 2) || (c == 10) || (c == 20);
      step();
      case (c)
        0: begin
          chk("hit0_vidas", int'(va), 2);
          chk("hit0_inv", int'(ia), 1);
        end
        2: begin
          chk("hit2_vidas", int'(va), 2);
          chk("hit2_inv", int'(ia), 1);
        end
        4: chk("inv_c4", int'(ia), 1);
        5: chk("inv_c5", int'(ia), 0);
        10: begin
          chk("hit10_vidas", int'(va), 1);
          chk("hit10_inv", int'(ia), 1);
        end
        19: chk("c19_fim", int'(fa), 0);
        20: begin
          chk("hit20_vidas", int'(va), 0);
          chk("hit20_fim", int'(fa), 1);
          chk("hit20_inv", int'(ia), 0);
        end
        default: ;
      endcase
    end
    bateu = 1'b0;

    // FIM holds position, lives and fire
    keys = 4'b0001; tiro = 1'b1; cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (pa) cnt++;
    end
    chk("fim_x", int'(xa), 620);
    chk("fim_vidas", int'(va), 0);
    chk("fim_pulso_cnt", cnt, 0);
    chk("fim_stay", int'(fa), 1);

    // Restart from FIM
    keys = '0; tiro = 1'b0; rein = 1'b1;
    step();
    rein = 1'b0;
    chk("rein_x", int'(xa), 620);
    chk("rein_y", int'(ya), 420);
    chk("rein_vidas", int'(va), 3);
    chk("rein_fim", int'(fa), 0);
    chk("rein_inv", int'(ia), 0);
    chk("rein_pulso", int'(pa), 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
